tt_um_seq_divider: RTL

//  Sequential unsigned 8-bit / 4-bit restoring divider. Inverse operation of the 4x4 array multiplier tile.

---
 rtl/tt_um_seq_divider_pkg.sv | 24 ++
 rtl/tt_um_seq_divider_div_step.sv | 50 +++++
 rtl/tt_um_seq_divider.sv | 112 +++++++++++
 3 files changed

// File: rtl/tt_um_seq_divider_pkg.sv
// Shared widths, state encoding and pin map for the sequential divider tile.
package tt_um_seq_divider_pkg;

  localparam int N_W   = 8;        // dividend / quotient width
  localparam int D_W   = 4;        // divisor width
  localparam int R_W   = D_W + 1;  // partial remainder width (one guard bit)
  localparam int CNT_W = 3;        // iteration counter, wraps after N_W steps

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N_W-1:0] DIV0_QUOT = 8'hFF;

  localparam int START_BIT = 4;
  localparam int SEL_BIT   = 5;
  localparam int BUSY_BIT  = 6;
  localparam int DONE_BIT  = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'b1100_0000;

endpackage

// File: rtl/tt_um_seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor with a ripple of full adders, keep the difference
// when there is no borrow.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module div_step
  import tt_um_seq_divider_pkg::*;
(
  input  logic [R_W-1:0] rem_in,
  input  logic           bit_in,
  input  logic [D_W-1:0] divisor,
  output logic [R_W-1:0] rem_out,
  output logic           q_bit
);

  logic [R_W-1:0] shifted;
  logic [R_W-1:0] sub_b;
  logic [R_W-1:0] diff;
  logic [R_W:0]   carry;

  assign shifted  = {rem_in[R_W-2:0], bit_in};
  assign sub_b    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < R_W; i++) begin : g_sub
    full_adder u_fa (
      .a   (shifted[i]),
      .b   (sub_b[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  // A set top bit of rem_in means the shifted value is at least 32, so it
  // always exceeds a 4-bit divisor and the 5-bit difference is still exact.
  assign q_bit   = carry[R_W] | rem_in[R_W-1];
  assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/tt_um_seq_divider.sv
// Sequential 8-bit / 4-bit restoring divider tile with start/busy/done
// handshake on the bidirectional pins.
//
//  state | meaning
//  IDLE  | waiting for first start edge, outputs show reset result (0)
//  CALC  | one quotient bit per clock, 8 iterations, busy=1
//  DONE  | result registers valid, done=1 until the next accepted start

module tt_um_seq_divider
  import tt_um_seq_divider_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             accept, load, div_zero;
  logic [CNT_W-1:0] cnt_q;
  logic [N_W-1:0]   dvd_q, quo_q, quot_res, rem_res;
  logic [D_W-1:0]   div_q;
  logic [R_W-1:0]   rem_q, rem_d;
  logic             q_bit;
  logic             unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in[7:6]};

  assign accept   = s2 & ~s3;
  assign load     = accept & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign div_zero = (uio_in[D_W-1:0] == '0);

  // start synchroniser plus edge-detect delay flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= uio_in[START_BIT];
      s2 <= s1;
      s3 <= s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept) state_d = div_zero ? ST_DONE : ST_CALC;
      ST_CALC:          if (cnt_q == 3'd7) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  div_step u_step (
    .rem_in (rem_q),
    .bit_in (dvd_q[N_W-1]),
    .divisor(div_q),
    .rem_out(rem_d),
    .q_bit  (q_bit)
  );

  // operand latch, iteration shift registers and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      quot_res <= '0;
      rem_res  <= '0;
    end else if (load) begin
      if (div_zero) begin
        quot_res <= DIV0_QUOT;
        rem_res  <= ui_in;
      end else begin
        dvd_q <= ui_in;
        div_q <= uio_in[D_W-1:0];
        rem_q <= '0;
        quo_q <= '0;
        cnt_q <= '0;
      end
    end else if (state_q == ST_CALC) begin
      dvd_q <= {dvd_q[N_W-2:0], 1'b0};
      rem_q <= rem_d;
      quo_q <= {quo_q[N_W-2:0], q_bit};
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        quot_res <= {quo_q[N_W-2:0], q_bit};
        rem_res  <= {4'b0000, rem_d[D_W-1:0]};
      end
    end
  end

  assign uo_out  = uio_in[SEL_BIT] ? rem_res : quot_res;
  assign uio_out = {state_q == ST_DONE, state_q == ST_CALC, 6'b00_0000};
  assign uio_oe  = UIO_OE_VAL;

endmodule
